vram_arbiter: RTL and testbench

Single-port video RAM arbiter in the `pixel_clk` domain. It shares one 2048x8 video RAM port between two users: the display scan-out read path, which always wins while the active window is open, and a write client, which fills or updates the image. Writes are accepted through a valid/ready handshake into a small FIFO. They are drained into the RAM only during blanking, after a one-cycle turnaround. The block sits between the LCD timing generator, the image loader and the video RAM instance.

---
 rtl/vram_arbiter_if.sv | 48 ++++
 rtl/vram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// ============================================================================
//  Module      : vram_arbiter_if
//  Description : Bus bundle between the VRAM arbiter, the scan-out timing,
//                the image loader and the video RAM port. stall_cnt exists
//                only when VRAM_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vram_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          active;
    logic [AW-1:0] rd_addr;
    logic          frame_start;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic          ram_wre;
    logic          busy;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    // Arbiter side
    modport slave (
        input  active, rd_addr, frame_start, wr_valid, wr_addr, wr_data,
        output wr_ready, ram_ad, ram_din, ram_wre, busy
`ifdef VRAM_ARB_STATS_EN
        , output stall_cnt
`endif
    );

    // Environment side (timing generator, loader, RAM)
    modport master (
        output active, rd_addr, frame_start, wr_valid, wr_addr, wr_data,
        input  wr_ready, ram_ad, ram_din, ram_wre, busy
`ifdef VRAM_ARB_STATS_EN
        , input stall_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port VRAM arbiter: scan-out reads own the RAM while
//                the display window is open, queued writes drain in blanking.
//                Optional macro VRAM_ARB_STATS_EN adds the stall_cnt counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  wire logic    pixel_clk,
    input  wire logic    rst,
    vram_arbiter_if.slave bus
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_PW = c_IW + 1;
    localparam int c_EW = AW + DW;
    localparam logic [c_PW-1:0] c_PTR_ONE = {{(c_PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_DISP  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_EW-1:0] r_mem [DEPTH];

    logic [AW-1:0]   r_ram_ad;
    logic [DW-1:0]   r_ram_din;
    logic            r_ram_wre;

    logic            w_full;
    logic            w_empty;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;
    logic [AW-1:0]   w_ad_nxt;
    logic [DW-1:0]   w_din_nxt;
    logic            w_wre_nxt;

    // ------------------------------------------------------------------------
    // Write FIFO: one extra pointer bit separates full from empty
    // ------------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PW-1] != r_rptr[c_PW-1]) &&
                     (r_wptr[c_IW-1:0] == r_rptr[c_IW-1:0]);
    assign w_ready = rst && !w_full;
    assign w_push  = bus.wr_valid && w_ready;
    assign w_head  = r_mem[r_rptr[c_IW-1:0]];

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset; reset empties the FIFO through the pointers
    always_ff @(posedge pixel_clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_IW-1:0]] <= {bus.wr_addr, bus.wr_data};
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_DISP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ad_nxt    = r_ram_ad;
        w_din_nxt   = r_ram_din;
        w_wre_nxt   = 1'b0;
        // An open window always wins, even mid-drain: no pop on that edge
        if (bus.active) begin
            w_state_nxt = ST_DISP;
            w_ad_nxt    = bus.rd_addr;
        end else begin
            case (r_state)
                ST_DISP: begin
                    w_state_nxt = ST_GAP;
                end
                ST_GAP: begin
                    w_state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    w_state_nxt = ST_DRAIN;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_ad_nxt  = w_head[c_EW-1:DW];
                        w_din_nxt = w_head[DW-1:0];
                        w_wre_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_DISP;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            r_ram_ad  <= '0;
            r_ram_din <= '0;
            r_ram_wre <= 1'b0;
        end else begin
            r_ram_ad  <= w_ad_nxt;
            r_ram_din <= w_din_nxt;
            r_ram_wre <= w_wre_nxt;
        end
    end

    assign bus.wr_ready = w_ready;
    assign bus.ram_ad   = r_ram_ad;
    assign bus.ram_din  = r_ram_din;
    assign bus.ram_wre  = r_ram_wre;
    assign bus.busy     = !w_empty || r_ram_wre;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Frame start clears even when a stall lands on the same cycle
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.frame_start) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.wr_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Directed self-checking bench for vram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic pixel_clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   k;
    int   j;
    logic hs;

    vram_arbiter_if #(.AW(11), .DW(8)) bus ();

    vram_arbiter #(.AW(11), .DW(8), .DEPTH(4)) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b0;
        bus.active      = 1'b1;
        bus.rd_addr     = '0;
        bus.frame_start = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        #1;
        check("rst_wr_ready_low", 32'(bus.wr_ready), 32'h0);
        check("rst_ram_wre",      32'(bus.ram_wre),  32'h0);
        check("rst_ram_ad",       32'(bus.ram_ad),   32'h0);
        check("rst_busy",         32'(bus.busy),     32'h0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rel_wr_ready", 32'(bus.wr_ready), 32'h1);

        // Active priority: reads own the RAM while writes pile up
        bus.rd_addr  = 11'h123;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_addr = 11'(11'h010 + i);
            bus.wr_data = 8'(8'hA0 + i);
            tick();
            check("act_ram_ad",  32'(bus.ram_ad),  32'h123);
            check("act_ram_wre", 32'(bus.ram_wre), 32'h0);
        end
        check("act_full_ready", 32'(bus.wr_ready), 32'h0);
        check("act_busy",       32'(bus.busy),     32'h1);
        bus.wr_addr = 11'h099;
        bus.wr_data = 8'hFF;
        tick();
        check("act_full_hold", 32'(bus.wr_ready), 32'h0);
        bus.wr_valid = 1'b0;

        // Drain: two quiet edges, then four ordered writes
        bus.active = 1'b0;
        tick();
        check("gap0_wre",  32'(bus.ram_wre), 32'h0);
        check("gap0_ad",   32'(bus.ram_ad),  32'h123);
        tick();
        check("gap1_wre",  32'(bus.ram_wre), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drn_wre", 32'(bus.ram_wre), 32'h1);
            check("drn_ad",  32'(bus.ram_ad),  32'h010 + i);
            check("drn_din", 32'(bus.ram_din), 32'hA0 + i);
        end
        tick();
        check("drn_end_wre",  32'(bus.ram_wre), 32'h0);
        check("drn_end_busy", 32'(bus.busy),    32'h0);
        check("drn_end_ad",   32'(bus.ram_ad),  32'h013);

        // Best-case write latency in DRAIN
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'h055;
        bus.wr_data  = 8'h5A;
        tick();
        bus.wr_valid = 1'b0;
        check("lat_n_wre",   32'(bus.ram_wre), 32'h0);
        check("lat_n_busy",  32'(bus.busy),    32'h1);
        tick();
        check("lat_n1_wre",  32'(bus.ram_wre), 32'h1);
        check("lat_n1_ad",   32'(bus.ram_ad),  32'h055);
        check("lat_n1_din",  32'(bus.ram_din), 32'h5A);

        // Interrupted drain
        bus.active   = 1'b1;
        bus.rd_addr  = 11'h200;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_addr = 11'(11'h020 + i);
            bus.wr_data = 8'(8'hB0 + i);
            tick();
        end
        check("int_rd_ad", 32'(bus.ram_ad), 32'h200);
        bus.wr_valid = 1'b0;
        bus.active   = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("int_a_wre", 32'(bus.ram_wre), 32'h1);
            check("int_a_ad",  32'(bus.ram_ad),  32'h020 + i);
        end
        bus.active  = 1'b1;
        bus.rd_addr = 11'h321;
        tick();
        check("int_stop_wre",  32'(bus.ram_wre), 32'h0);
        check("int_stop_ad",   32'(bus.ram_ad),  32'h321);
        check("int_stop_busy", 32'(bus.busy),    32'h1);
        bus.active = 1'b0;
        tick();
        check("int_gap0_wre", 32'(bus.ram_wre), 32'h0);
        tick();
        check("int_gap1_wre", 32'(bus.ram_wre), 32'h0);
        for (int i = 2; i < 4; i++) begin
            tick();
            check("int_b_wre", 32'(bus.ram_wre), 32'h1);
            check("int_b_ad",  32'(bus.ram_ad),  32'h020 + i);
            check("int_b_din", 32'(bus.ram_din), 32'hB0 + i);
        end
        tick();
        check("int_end_busy", 32'(bus.busy), 32'h0);

        // Full FIFO with simultaneous push/pop, 20 writes in order
        bus.active   = 1'b1;
        bus.wr_valid = 1'b1;
        k = 0;
        j = 0;
        bus.wr_addr = 11'h100;
        bus.wr_data = 8'd3;
        for (int cyc = 0; cyc < 100 && j < 20; cyc++) begin
            if (cyc == 4) bus.active = 1'b0;
            hs = bus.wr_valid && bus.wr_ready;
            tick();
            if (hs) begin
                k++;
                if (k < 20) begin
                    bus.wr_addr = 11'(11'h100 + k);
                    bus.wr_data = 8'(k * 7 + 3);
                end else begin
                    bus.wr_valid = 1'b0;
                end
            end
            if (bus.ram_wre) begin
                check("s20_ad",  32'(bus.ram_ad),  32'h100 + j);
                check("s20_din", 32'(bus.ram_din), 32'((j * 7 + 3) & 8'hFF));
                j++;
            end
        end
        check("s20_count", 32'(j), 32'd20);
        bus.wr_valid = 1'b0;
        tick();
        check("s20_no_extra", 32'(bus.ram_wre), 32'h0);
        check("s20_busy",     32'(bus.busy),    32'h0);

        // Reset mid-drain with three entries still queued
        bus.active   = 1'b1;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_addr = 11'(11'h030 + i);
            bus.wr_data = 8'(8'hC0 + i);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.active   = 1'b0;
        tick();
        tick();
        tick();
        check("mid_wre", 32'(bus.ram_wre), 32'h1);
        check("mid_ad",  32'(bus.ram_ad),  32'h030);
        rst = 1'b0;
        #1;
        check("ares_wre",   32'(bus.ram_wre),  32'h0);
        check("ares_ad",    32'(bus.ram_ad),   32'h0);
        check("ares_din",   32'(bus.ram_din),  32'h0);
        check("ares_ready", 32'(bus.wr_ready), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("arel_ready", 32'(bus.wr_ready), 32'h1);
        check("arel_busy",  32'(bus.busy),     32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arel_discard_wre", 32'(bus.ram_wre), 32'h0);
        end

`ifdef VRAM_ARB_STATS_EN
        check("st_reset", 32'(bus.stall_cnt), 32'h0);
        bus.active   = 1'b1;
        bus.wr_valid = 1'b1;
        repeat (4) tick();
        check("st_fill", 32'(bus.stall_cnt), 32'h0);
        repeat (7) tick();
        check("st_seven", 32'(bus.stall_cnt), 32'd7);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("st_clear_wins", 32'(bus.stall_cnt), 32'h0);
        repeat (70000) tick();
        check("st_saturate", 32'(bus.stall_cnt), 32'hFFFF);
        bus.wr_valid = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("st_clear", 32'(bus.stall_cnt), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
